mem_sequencer: RTL

Multi-cycle memory sequencer between the LC-3 control unit and the external asynchronous SRAM. Turns the control unit's level-held `Mem_OE`/`Mem_WE` requests into correctly timed SRAM strobe sequences, returns read data to the MDR path, and decodes one memory-mapped I/O word (switch input on read, hex display register on write). All SRAM strobes are Moore-decoded from the state register, so none can glitch.

---
 rtl/mem_sequencer_if.sv | 33 +++
 rtl/mem_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mem_sequencer_if.sv
// rtl/mem_sequencer_if.sv - control-unit, I/O and SRAM signal bundle for mem_sequencer
interface mem_sequencer_if;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] MAR;
  logic [15:0] MDR_out;
  logic [15:0] Switches;
  logic [15:0] Data_from_SRAM;
  logic [15:0] Rdata;
  logic        Ack;
  logic        Busy;
  logic [15:0] HEX_data;
  logic [19:0] SRAM_ADDR;
  logic [15:0] Data_to_SRAM;
  logic        Data_oe;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;

  modport master (
    output Mem_OE, Mem_WE, MAR, MDR_out, Switches, Data_from_SRAM,
    input  Rdata, Ack, Busy, HEX_data, SRAM_ADDR, Data_to_SRAM, Data_oe,
    input  SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N
  );

  modport slave (
    input  Mem_OE, Mem_WE, MAR, MDR_out, Switches, Data_from_SRAM,
    output Rdata, Ack, Busy, HEX_data, SRAM_ADDR, Data_to_SRAM, Data_oe,
    output SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N
  );
endinterface

// File: rtl/mem_sequencer.sv
// rtl/mem_sequencer.sv - LC-3 memory sequencer: timed async-SRAM strobes plus one memory-mapped I/O word
module mem_sequencer #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input logic             Clk,
  input logic             Reset_n,
  mem_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ACC,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] hex_q, hex_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        data_oe_q, data_oe_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        bl_n_q, bl_n_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 4'd1;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;

    case (state_q)
      IDLE: begin
        if (bus.Mem_WE || bus.Mem_OE) begin
          addr_d  = bus.MAR;
          wdata_d = bus.MDR_out;
          // A simultaneous read request is dropped: the write wins.
          if (bus.Mem_WE) begin
            if (bus.MAR == IO_ADDR) begin
              hex_d   = bus.MDR_out;
              state_d = DONE;
            end else begin
              state_d = WR_SETUP;
            end
          end else if (bus.MAR == IO_ADDR) begin
            rdata_d = bus.Switches;
            state_d = DONE;
          end else begin
            state_d = RD_ACC;
          end
        end
      end
      RD_ACC: begin
        if (cnt_q == LAST_CNT) begin
          rdata_d = bus.Data_from_SRAM;
          state_d = DONE;
        end
      end
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: begin
        if (cnt_q == LAST_CNT) begin
          state_d = WR_HOLD;
        end
      end
      WR_HOLD: state_d = DONE;
      DONE: begin
        if (!bus.Mem_OE && !bus.Mem_WE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = 4'd0;
    end

    // Strobes are decoded from the next state so each registered copy matches state_q exactly.
    ce_n_d    = !(state_d inside {RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD});
    bl_n_d    = ce_n_d;
    oe_n_d    = (state_d != RD_ACC);
    we_n_d    = (state_d != WR_PULSE);
    data_oe_d = (state_d inside {WR_SETUP, WR_PULSE, WR_HOLD});
    ack_d     = (state_d == DONE);
    busy_d    = !ce_n_d;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 16'd0;
      wdata_q   <= 16'd0;
      rdata_q   <= 16'd0;
      hex_q     <= 16'd0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      data_oe_q <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      bl_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      hex_q     <= hex_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      data_oe_q <= data_oe_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      bl_n_q    <= bl_n_d;
    end
  end

  assign bus.Rdata        = rdata_q;
  assign bus.Ack          = ack_q;
  assign bus.Busy         = busy_q;
  assign bus.HEX_data     = hex_q;
  assign bus.SRAM_ADDR    = {4'b0000, addr_q};
  assign bus.Data_to_SRAM = wdata_q;
  assign bus.Data_oe      = data_oe_q;
  assign bus.SRAM_CE_N    = ce_n_q;
  assign bus.SRAM_OE_N    = oe_n_q;
  assign bus.SRAM_WE_N    = we_n_q;
  assign bus.SRAM_UB_N    = bl_n_q;
  assign bus.SRAM_LB_N    = bl_n_q;

endmodule
